// File: rtl/ins_mem_ctrl.sv
// Instruction memory with a program-load write port and a fixed-latency,
// fully pipelined fetch path that can be frozen by the consumer.
module ins_mem_ctrl #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        ins_mem_clock_in,
  input  logic        ins_mem_reset_in,
  input  logic        ins_mem_req_in,
  input  logic [31:0] ins_mem_addr_in,
  output logic        ins_mem_ready_out,
  input  logic        ins_mem_hold_in,
  output logic [31:0] ins_mem_data_out,
  output logic        ins_mem_valid_out,
  output logic        ins_mem_err_out,
  input  logic        ins_mem_load_en_in,
  input  logic [31:0] ins_mem_load_addr_in,
  input  logic [31:0] ins_mem_load_data_in
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int IDX_W = DEPTH_LOG2;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("ins_mem_ctrl: LATENCY must be in 1..4");
  end

  logic [31:0]                  mem [WORDS];
  logic [LATENCY-1:0]           stg_valid;
  logic [LATENCY-1:0]           stg_err;
  logic [LATENCY-1:0][IDX_W-1:0] stg_idx;
  logic [31:0]                  data_q;

  logic             accept;
  logic             req_err;
  logic [IDX_W-1:0] req_idx;
  logic             load_hit;
  logic             fin_valid;
  logic             fin_err;
  logic [IDX_W-1:0] fin_idx;
  logic             unused_bits;

  // Handshake: a fetch is taken on the rising edge where req && ready;
  // ready drops while the consumer holds or a program load owns the array.
  assign ins_mem_ready_out = !ins_mem_hold_in && !ins_mem_load_en_in;
  assign accept            = ins_mem_req_in && ins_mem_ready_out;

  assign req_err  = (ins_mem_addr_in[1:0] != 2'b00) ||
                    ((ins_mem_addr_in >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign req_idx  = ins_mem_addr_in[DEPTH_LOG2+1:2];
  assign load_hit = ins_mem_load_en_in &&
                    ((ins_mem_load_addr_in >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign unused_bits = ^ins_mem_load_addr_in[1:0];

  // The memory is read on the edge that loads the final stage, so the entry
  // feeding that stage is either the live request or the previous stage.
  if (LATENCY == 1) begin : g_fin_req
    assign fin_valid = accept;
    assign fin_err   = req_err;
    assign fin_idx   = req_idx;
  end else begin : g_fin_stg
    assign fin_valid = stg_valid[LATENCY-2];
    assign fin_err   = stg_err[LATENCY-2];
    assign fin_idx   = stg_idx[LATENCY-2];
  end

  // Contents survive reset; reset only blocks writes while it is asserted.
  always_ff @(posedge ins_mem_clock_in or negedge ins_mem_reset_in) begin
    if (!ins_mem_reset_in) begin
    end else if (load_hit) begin
      mem[ins_mem_load_addr_in[DEPTH_LOG2+1:2]] <= ins_mem_load_data_in;
    end
  end

  always_ff @(posedge ins_mem_clock_in or negedge ins_mem_reset_in) begin
    if (!ins_mem_reset_in) begin
      stg_valid <= '0;
      stg_err   <= '0;
      stg_idx   <= '0;
      data_q    <= '0;
    end else if (!ins_mem_hold_in) begin
      stg_valid[0] <= accept;
      stg_err[0]   <= accept && req_err;
      stg_idx[0]   <= req_idx;
      for (int i = 1; i < LATENCY; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_err[i]   <= stg_err[i-1];
        stg_idx[i]   <= stg_idx[i-1];
      end
      data_q <= (fin_valid && !fin_err) ? mem[fin_idx] : 32'd0;
    end
  end

  assign ins_mem_valid_out = stg_valid[LATENCY-1];
  assign ins_mem_err_out   = stg_err[LATENCY-1];
  assign ins_mem_data_out  = data_q;

endmodule

// File: tb/tb_ins_mem_ctrl.sv
// Drives four ins_mem_ctrl instances (LATENCY 1..4) with shared stimulus and
// compares each against a timestamp-based reference of the fetch pipeline.
module tb_ins_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        hold;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        ready_o [4];
  logic        valid_o [4];
  logic        err_o   [4];
  logic [31:0] data_o  [4];

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ins_mem_ctrl #(.DEPTH_LOG2(10), .LATENCY(g + 1)) u_dut (
      .ins_mem_clock_in     (clk),
      .ins_mem_reset_in     (rst_n),
      .ins_mem_req_in       (req),
      .ins_mem_addr_in      (addr),
      .ins_mem_ready_out    (ready_o[g]),
      .ins_mem_hold_in      (hold),
      .ins_mem_data_out     (data_o[g]),
      .ins_mem_valid_out    (valid_o[g]),
      .ins_mem_err_out      (err_o[g]),
      .ins_mem_load_en_in   (load_en),
      .ins_mem_load_addr_in (load_addr),
      .ins_mem_load_data_in (load_data)
    );
  end

  // Reference: each accepted fetch is stamped with the count of advancing
  // (non-held) edges; a LATENCY=L response appears once L such edges passed.
  typedef struct {
    int unsigned stamp;
    logic        bad;
    logic [31:0] addr;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] mem_m [1024];
  int unsigned adv_cnt = 0;
  logic        m_valid [4];
  logic        m_err   [4];
  logic [31:0] m_data  [4];

  function automatic logic is_bad(input logic [31:0] a);
    return ((a % 4) != 0) || (a >= 32'd4096);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int d = 0; d < 4; d++) begin
      m_valid[d] = 1'b0;
      m_err[d]   = 1'b0;
      m_data[d]  = 32'd0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (!hold) begin
      adv_cnt++;
      if (req && !load_en) exp_q.push_back('{adv_cnt, is_bad(addr), addr});
      for (int d = 0; d < 4; d++) begin
        m_valid[d] = 1'b0;
        m_err[d]   = 1'b0;
        m_data[d]  = 32'd0;
        foreach (exp_q[i]) begin
          if (exp_q[i].stamp + d == adv_cnt) begin
            m_valid[d] = 1'b1;
            m_err[d]   = exp_q[i].bad;
            m_data[d]  = exp_q[i].bad ? 32'd0 : mem_m[exp_q[i].addr / 4];
          end
        end
      end
      while (exp_q.size() > 0 && exp_q[0].stamp + 3 < adv_cnt) void'(exp_q.pop_front());
    end
    // The read above sees the array as it was before this edge's load.
    if (load_en && load_addr < 32'd4096) mem_m[load_addr / 4] = load_data;
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 4; d++) begin
      check($sformatf("ready[L=%0d]", d + 1), 32'(ready_o[d]), 32'(!hold && !load_en));
      check($sformatf("valid[L=%0d]", d + 1), 32'(valid_o[d]), 32'(m_valid[d]));
      check($sformatf("err[L=%0d]", d + 1), 32'(err_o[d]), 32'(m_err[d]));
      if (m_valid[d]) check($sformatf("data[L=%0d]", d + 1), data_o[d], m_data[d]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic h,
                       input logic le, input logic [31:0] la, input logic [31:0] ld);
    req       = r;
    addr      = a;
    hold      = h;
    load_en   = le;
    load_addr = la;
    load_data = ld;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_valid[L=%0d]", d + 1), 32'(valid_o[d]), 32'd0);
      check($sformatf("rst_err[L=%0d]", d + 1), 32'(err_o[d]), 32'd0);
      check($sformatf("rst_data[L=%0d]", d + 1), data_o[d], 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(9))
      0:       return ($urandom_range(1023) * 4) | $urandom_range(3, 1);
      1:       return $urandom | 32'h0000_1000;
      default: return $urandom_range(1023) * 4;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    model_clear();
    assert_reset();
    step();
    step();
    @(negedge clk);
    #0 rst_n = 1'b1;
    idle(1);

    // Program load of the whole array; fetch requests meanwhile must be refused.
    for (int i = 0; i < 1024; i++) begin
      drive(1'($urandom_range(1)), 32'(i * 4), 1'b0, 1'b1,
            32'(i * 4) | $urandom_range(3),
            (i == 0) ? 32'h0000_0013 : (i == 1) ? 32'h0010_0093 : $urandom);
      step();
    end
    idle(2);

    // Back-to-back fetches of the two known words.
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0); step();
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0); step();
    idle(5);

    // Misaligned and out-of-range fetches.
    drive(1'b1, 32'h2, 1'b0, 1'b0, 32'd0, 32'd0); step();
    drive(1'b1, 32'h1000, 1'b0, 1'b0, 32'd0, 32'd0); step();
    idle(5);

    // Three fetches then a three-cycle hold with a request pending.
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0); step();
    drive(1'b1, 32'hC, 1'b0, 1'b0, 32'd0, 32'd0); step();
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0); step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h14, 1'b1, 1'b0, 32'd0, 32'd0);
      step();
    end
    idle(6);

    // Load collides with a request, then the loaded word is fetched.
    drive(1'b1, 32'h20, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D); step();
    drive(1'b1, 32'h20, 1'b0, 1'b0, 32'd0, 32'd0); step();
    idle(6);

    // Reset with two fetches in flight; a load during reset is ignored.
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0); step();
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0); step();
    drive(1'b1, 32'hC, 1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF);
    assert_reset();
    step();
    step();
    @(negedge clk);
    #0 rst_n = 1'b1;
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0); step();
    idle(6);

    // Alternating requests give alternating responses.
    for (int i = 0; i < 20; i++) begin
      drive(1'(i % 2 == 0), $urandom_range(1023) * 4, 1'b0, 1'b0, 32'd0, 32'd0);
      step();
    end
    idle(5);

    // Randomized traffic with holds, loads and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(3) != 0), rand_addr(), 1'($urandom_range(4) == 0),
            1'($urandom_range(9) == 0),
            ($urandom_range(9) == 0) ? ($urandom | 32'h0000_1000) : 32'($urandom_range(4095)),
            $urandom);
      if ($urandom_range(199) == 0) assert_reset();
      else rst_n = 1'b1;
      step();
    end
    rst_n = 1'b1;
    idle(8);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
